// File: rtl/cpu_test_disk_pkg.sv
// Shared widths, pattern constants and the reference pattern function for the
// test-word generator, so fill and compare logic elsewhere can reuse it.
package cpu_test_disk_pkg;

  localparam int IDX_W  = 8;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 1 << IDX_W;

  localparam logic [IDX_W-1:0] PAT_XOR = 8'h55;
  localparam logic [IDX_W-1:0] PAT_INC = 8'h01;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [WORD_W-1:0] word_t;

  // Byte 3 carries the index itself, which makes every word unique.
  function automatic word_t pattern(input idx_t idx);
    idx_t b2, b1, b0;
    b2 = ~idx;
    b1 = idx ^ PAT_XOR;
    b0 = idx + PAT_INC;
    return {idx, b2, b1, b0};
  endfunction

endpackage

// File: rtl/cpu_test_disk_rom.sv
// Combinational 256 x 32 lookup of the test pattern, built as a constant table
// indexed directly by the word index.
module cpu_test_disk_rom
  import cpu_test_disk_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  word_t rom_tbl [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
    assign rom_tbl[gi] = pattern(idx_t'(gi));
  end

  assign word = rom_tbl[idx];

endmodule

// File: rtl/cpu_test_disk.sv
// Reference-data generator: registers pattern(addr) with one cycle of latency;
// reset forces the output to zero, which is never a valid pattern word.
module cpu_test_disk
  import cpu_test_disk_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  addr,
  output logic [WORD_W-1:0] data
);

  word_t rom_word;
  word_t data_d;
  word_t data_q;

  cpu_test_disk_rom u_rom (
    .idx  (addr),
    .word (rom_word)
  );

  always_comb begin
    data_d = rom_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_cpu_test_disk.sv
// Scoreboard bench for cpu_test_disk: the driver queues expected words from a
// byte-level model, and an independent monitor checks one word per clock.
module tb_cpu_test_disk;

  logic        clk;
  logic        reset;
  logic [7:0]  addr;
  logic [31:0] data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] exp;
    logic [7:0]  a;
    logic        rst;
    bit          sweep;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  bit          seen[logic [31:0]];
  logic [31:0] mem [256];

  cpu_test_disk dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each byte computed arithmetically from the index.
  function automatic logic [31:0] model(input int n);
    int b3, b2, b1, b0;
    b3 = n % 256;
    b2 = 255 - b3;
    b1 = b3 ^ 'h55;
    b0 = (b3 + 1) % 256;
    return (b3 << 24) | (b2 << 16) | (b1 << 8) | b0;
  endfunction

  task automatic step(input logic r, input logic [7:0] a, input string tag,
                      input bit sweep = 0, input logic [31:0] exp_ovr = 32'h0,
                      input bit use_ovr = 0);
    exp_t e;
    @(negedge clk);
    reset = r;
    addr  = a;
    e.a     = a;
    e.rst   = r;
    e.sweep = sweep;
    e.tag   = tag;
    if (r)            e.exp = 32'h0;
    else if (use_ovr) e.exp = exp_ovr;
    else              e.exp = model(int'(a));
    sb_q.push_back(e);
  endtask

  // Monitor: the output is valid every cycle, so each edge retires one entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (data !== e.exp) begin
          failures++;
          $display("FAIL %s addr=%02h reset=%0b got=%08h want=%08h",
                   e.tag, e.a, e.rst, data, e.exp);
        end
        if (e.sweep) seen[data] = 1'b1;
      end
    end
  end

  initial begin
    int waited;
    int order[256];
    int j, tmp;
    reset = 1'b1;
    addr  = 8'h00;

    // Reset held with a live index, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h5A, "reset_hold");
    step(1'b0, 8'h5A, "post_reset", 0, 32'h5AA5_0F5B, 1);

    // Directed values, including byte-0 wrap.
    step(1'b0, 8'h00, "idx_00", 0, 32'h00FF_5501, 1);
    step(1'b0, 8'hFF, "idx_ff_wrap", 0, 32'hFF00_AA00, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h80, "hold_80", 0, 32'h807F_D581, 1);

    // Clean sweep; observed words recorded for the distinctness check.
    for (int i = 0; i < 256; i++) step(1'b0, 8'(i), "sweep", 1);

    // Sweep with a one-cycle reset at index 0x40.
    for (int i = 0; i < 256; i++) step((i == 'h40), 8'(i), "sweep_rst");

    // Random addresses with occasional reset.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)), "random");

    // Fill a memory model, then read back in shuffled order against the DUT.
    for (int i = 0; i < 256; i++) mem[i] = model(i);
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++)
      step(1'b0, 8'(order[i]), "fill_compare", 0, mem[order[i]], 1);

    // Drain, bounded.
    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    checks++;
    if (seen.num() != 256) begin
      failures++;
      $display("FAIL distinct got=%0d required=256", seen.num());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
